// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields into 32-bit instruction words.
// Illegal field combinations are replaced by NOP_WORD and flagged on 'invalid'.
// Input/output are valid/ready streams joined by a 2-entry skid buffer
// (output register + skid register) so that in_ready is purely registered.
module instr_encoder #(
  parameter int          CNT_W    = 16,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic             invalid,
  output logic [31:0]      accept_count,
  output logic [CNT_W-1:0] invalid_count
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef struct packed {
    logic [31:0] word;
    logic        inv;
  } enc_t;

  enc_t enc, outq, skid;
  logic skid_vld, skid_nxt;
  logic acc, out_free;
  logic imm12_ok, is_shift, sh_f7_ok, op_f7_ok, bad;
  logic [31:0] word;

  assign acc      = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;
  assign skid_nxt = out_free ? (skid_vld && acc) : (skid_vld || acc);
  assign instr    = outq.word;
  assign invalid  = outq.inv;

  assign imm12_ok = (imm[31:11] == {21{imm[11]}});
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign sh_f7_ok = (funct7 == 7'b0000000) ||
                    (funct7 == 7'b0100000 && funct3 == 3'b101);
  assign op_f7_ok = (funct7 == 7'b0000000) ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));

  // Format selection and legality check for the bundle on the input port.
  always_comb begin
    word = NOP_WORD;
    bad  = 1'b0;
    case (opcode)
      OP_OP: begin
        bad  = !op_f7_ok;
        word = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      OP_OPIMM: begin
        if (is_shift) begin
          bad  = !sh_f7_ok || (imm[31:5] != 27'd0);
          word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
        end else begin
          bad  = !imm12_ok;
          word = {imm[11:0], rs1, funct3, rd, opcode};
        end
      end
      OP_LOAD: begin
        bad  = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) || !imm12_ok;
        word = {imm[11:0], rs1, funct3, rd, opcode};
      end
      OP_JALR: begin
        bad  = (funct3 != 3'b000) || !imm12_ok;
        word = {imm[11:0], rs1, funct3, rd, opcode};
      end
      OP_STORE: begin
        bad  = (funct3 >= 3'b011) || !imm12_ok;
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      end
      OP_BRANCH: begin
        bad  = (funct3 == 3'b010) || (funct3 == 3'b011) || imm[0];
        word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      end
      OP_LUI, OP_AUIPC: begin
        word = {imm[31:12], rd, opcode};
      end
      OP_JAL: begin
        bad  = imm[0];
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      end
      default: bad = 1'b1;
    endcase
    enc.inv  = bad;
    enc.word = bad ? NOP_WORD : word;
  end

  // Skid buffer, registered in_ready and accept/invalid counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid     <= 1'b0;
      in_ready      <= 1'b0;
      outq          <= '0;
      skid          <= '0;
      skid_vld      <= 1'b0;
      accept_count  <= '0;
      invalid_count <= '0;
    end else begin
      if (out_free) begin
        if (skid_vld) begin
          outq      <= skid;
          out_valid <= 1'b1;
          if (acc) skid <= enc;
        end else begin
          out_valid <= acc;
          if (acc) outq <= enc;
        end
      end else if (acc) begin
        skid <= enc;
      end
      skid_vld <= skid_nxt;
      in_ready <= !skid_nxt;
      if (acc) begin
        accept_count <= accept_count + 32'd1;
        if (enc.inv && (invalid_count != {CNT_W{1'b1}}))
          invalid_count <= invalid_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: queue-based occupancy/ordering model plus a
// field-level reference encoder, directed scenarios and a random phase.
module tb_instr_encoder;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, invalid;
  logic [6:0]    opcode = '0, funct7 = '0;
  logic [2:0]    funct3 = '0;
  logic [4:0]    rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0]   imm = '0, instr, accept_count;
  logic [CW-1:0] invalid_count;

  instr_encoder #(.CNT_W(CW), .NOP_WORD(32'h0000_0013)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1),
    .rs2(rs2), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .instr(instr), .invalid(invalid), .accept_count(accept_count),
    .invalid_count(invalid_count));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic        inv;
  } ent_t;

  int checks = 0, passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference encoder built from field arithmetic and legal-funct3 masks.
  function automatic ent_t ref_enc(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic [4:0] d,
                                   input logic [4:0] s1, input logic [4:0] s2,
                                   input logic [31:0] im);
    ent_t r;
    int sv;
    bit in12, ok;
    logic [7:0] mask;
    logic [31:0] base, w;
    sv   = $signed(im);
    in12 = (sv >= -2048) && (sv <= 2047);
    base = (32'(s1) << 15) | (32'(f3) << 12) | (32'(d) << 7) | 32'(op);
    ok   = 1'b1;
    w    = 32'h13;
    case (op)
      7'h33: begin
        ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        w  = (32'(f7) << 25) | (32'(s2) << 20) | base;
      end
      7'h13: begin
        if (f3 == 1 || f3 == 5) begin
          ok = (im < 32) && (f7 == 0 || (f7 == 7'h20 && f3 == 5));
          w  = (32'(f7) << 25) | (im << 20) | base;
        end else begin
          ok = in12;
          w  = ((im & 32'hfff) << 20) | base;
        end
      end
      7'h03: begin
        mask = 8'h37; ok = mask[f3] && in12;
        w    = ((im & 32'hfff) << 20) | base;
      end
      7'h67: begin
        ok = (f3 == 0) && in12;
        w  = ((im & 32'hfff) << 20) | base;
      end
      7'h23: begin
        mask = 8'h07; ok = mask[f3] && in12;
        w    = (((im >> 5) & 127) << 25) | (32'(s2) << 20) | (32'(s1) << 15) |
               (32'(f3) << 12) | ((im & 31) << 7) | 32'(op);
      end
      7'h63: begin
        mask = 8'hF3; ok = mask[f3] && !im[0];
        w    = (((im >> 12) & 1) << 31) | (((im >> 5) & 63) << 25) | (32'(s2) << 20) |
               (32'(s1) << 15) | (32'(f3) << 12) | (((im >> 1) & 15) << 8) |
               (((im >> 11) & 1) << 7) | 32'(op);
      end
      7'h37, 7'h17: w = (im & 32'hffff_f000) | (32'(d) << 7) | 32'(op);
      7'h6F: begin
        ok = !im[0];
        w  = (((im >> 20) & 1) << 31) | (((im >> 1) & 1023) << 21) |
             (((im >> 11) & 1) << 20) | (((im >> 12) & 255) << 12) | (32'(d) << 7) | 32'(op);
      end
      default: ok = 1'b0;
    endcase
    r.inv = !ok;
    r.w   = ok ? w : 32'h13;
    return r;
  endfunction

  // Behavioural model: FIFO of at most 2 words, plus counters.
  ent_t        q[$];
  bit          m_after_rst = 1'b1;
  logic [31:0] m_acc = '0;
  int          m_inv = 0;

  // Compare DUT outputs against the model each cycle, then advance the model.
  always @(negedge clk) begin
    if (m_after_rst) begin
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst in_ready", 32'(in_ready), 32'd0);
      chk("rst instr", instr, 32'd0);
      chk("rst invalid", 32'(invalid), 32'd0);
    end else begin
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      if (q.size() > 0) begin
        chk("instr", instr, q[0].w);
        chk("invalid", 32'(invalid), 32'(q[0].inv));
      end
    end
    chk("accept_count", accept_count, m_acc);
    chk("invalid_count", 32'(invalid_count), 32'(m_inv));
    if (reset) begin
      q.delete();
      m_acc = '0;
      m_inv = 0;
      m_after_rst = 1'b1;
    end else begin
      bit mr, mv, a, e;
      ent_t n;
      mr = !m_after_rst && (q.size() < 2);
      mv = q.size() > 0;
      a  = in_valid && mr;
      e  = mv && out_ready;
      if (e) void'(q.pop_front());
      if (a) begin
        n = ref_enc(opcode, funct3, funct7, rd, rs1, rs2, imm);
        q.push_back(n);
        m_acc++;
        if (n.inv && m_inv < (1 << CW) - 1) m_inv++;
      end
      m_after_rst = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_f(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [31:0] im);
    opcode = op; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
  endtask

  task automatic send_chk(input string name, input logic [31:0] exp_w, input logic exp_inv);
    in_valid = 1'b1;
    chk({name, " model"}, ref_enc(opcode, funct3, funct7, rd, rs1, rs2, imm).w, exp_w);
    step();
    chk(name, instr, exp_w);
    chk({name, " inv"}, 32'(invalid), 32'(exp_inv));
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0;
    step();
    reset = 1'b0;
    step();
  endtask

  // Sequence of distinct ADDIs used by the backpressure scenarios.
  int k, nwords;
  logic [31:0] got[$];

  task automatic set_addi(input int i);
    set_f(7'h13, 3'd0, 7'd0, 5'(i + 1), 5'd2, 5'd0, 32'(10 + i));
  endtask

  function automatic logic [31:0] addi_w(input int i);
    return ref_enc(7'h13, 3'd0, 7'd0, 5'(i + 1), 5'd2, 5'd0, 32'(10 + i)).w;
  endfunction

  task automatic tick();
    bit rdy, vin;
    if (out_valid && out_ready) got.push_back(instr);
    rdy = in_ready; vin = in_valid;
    step();
    if (rdy && vin) begin
      k++;
      if (k < nwords) set_addi(k);
      else in_valid = 1'b0;
    end
  endtask

  task automatic start_seq(input int n);
    k = 0; nwords = n; got.delete();
    set_addi(0);
    in_valid = 1'b1;
  endtask

  function automatic logic [31:0] rnd_imm();
    case ($urandom_range(0, 6))
      0: return 32'($signed(12'($urandom)));
      1: return 32'd2047;
      2: return 32'hFFFF_F800;
      3: return 32'd2048;
      4: return 32'hFFFF_F7FF;
      5: return $urandom & 32'hFFFF_FFFE;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [6:0] ops[10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h0B};
    step(); step();
    reset = 1'b0;
    step();

    // Directed encodings.
    set_f(7'h13, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'd5);          send_chk("ADDI", 32'h00510093, 1'b0);
    set_f(7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0);          send_chk("SUB",  32'h402081B3, 1'b0);
    set_f(7'h13, 3'd5, 7'h20, 5'd1, 5'd2, 5'd0, 32'd3);          send_chk("SRAI", 32'h40315093, 1'b0);
    set_f(7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000);   send_chk("LUI",  32'h123452B7, 1'b0);
    set_f(7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8);          send_chk("BEQ",  32'h00208463, 1'b0);
    set_f(7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048);       send_chk("JAL",  32'h001000EF, 1'b0);
    in_valid = 1'b0;
    step();

    // Invalid bundles.
    do_reset();
    set_f(7'h0B, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'd0);          send_chk("bad opcode", 32'h13, 1'b1);
    set_f(7'h03, 3'd7, 7'h00, 5'd1, 5'd2, 5'd0, 32'd4);          send_chk("bad load",   32'h13, 1'b1);
    set_f(7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd3);          send_chk("bad beq",    32'h13, 1'b1);
    in_valid = 1'b0;
    step();
    chk("inv cnt 3", 32'(invalid_count), 32'd3);
    chk("acc cnt 3", accept_count, 32'd3);

    // Saturation of the narrow invalid counter.
    do_reset();
    set_f(7'h0B, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0);
    in_valid = 1'b1;
    repeat (5) step();
    in_valid = 1'b0;
    step();
    chk("sat inv cnt", 32'(invalid_count), 32'd3);
    chk("sat acc cnt", accept_count, 32'd5);

    // Backpressure: 4 ADDIs held against a stalled consumer.
    do_reset();
    out_ready = 1'b0;
    start_seq(4);
    repeat (4) tick();
    chk("bp accepts", 32'(k), 32'd2);
    chk("bp in_ready", 32'(in_ready), 32'd0);
    chk("bp hold", instr, addi_w(0));
    out_ready = 1'b1;
    repeat (8) tick();
    chk("bp count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("bp order", got[i], addi_w(i));

    // Single out_ready pulse with the skid full.
    do_reset();
    out_ready = 1'b0;
    start_seq(4);
    repeat (3) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    repeat (3) tick();
    chk("pulse accepts", 32'(k), 32'd3);
    chk("pulse in_ready", 32'(in_ready), 32'd0);
    chk("pulse acc cnt", accept_count, 32'd3);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick();
    chk("pulse count", 32'(got.size()), 32'd3);
    for (int i = 0; i < 3 && i < got.size(); i++) chk("pulse order", got[i], addi_w(i));

    // Reset with two words buffered.
    out_ready = 1'b0;
    start_seq(4);
    repeat (3) tick();
    reset = 1'b1;
    step();
    chk("mid rst out_valid", 32'(out_valid), 32'd0);
    chk("mid rst acc cnt", accept_count, 32'd0);
    chk("mid rst in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    step();
    chk("post rst in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 299) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      set_f(ops[$urandom_range(0, 9)], 3'($urandom),
            ($urandom_range(0, 3) == 0) ? 7'($urandom) : (($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20),
            5'($urandom), 5'($urandom), 5'($urandom),
            ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : rnd_imm());
      step();
    end
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
